// File: rtl/alu_opstage_pkg.sv
// Shared constants for the ID/EX operand stage: default widths, the hard-wired
// zero register, forwarding source indices and the statistics counter width.
package alu_opstage_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int NUM_FWD_DEF    = 2;

    // Register 0 always reads as zero, so it is never a forwarding target.
    localparam int ZERO_REG = 0;

    // Forwarding source ordering: lower index is the younger result.
    localparam int FWD_EXMEM = 0;
    localparam int FWD_MEMWB = 1;

    localparam int STATS_W = 16;

endpackage

// File: rtl/alu_operand_stage_fwd_select.sv
// Forwarding mux for one source register: picks the youngest matching in-flight
// result, or the register-file read data when nothing matches.
module fwd_select
    import alu_opstage_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int NUM_FWD    = NUM_FWD_DEF
) (
    input  logic [REG_ADDR_W-1:0]         regAddr,
    input  logic [DATA_W-1:0]             regData,
    input  logic [NUM_FWD-1:0]            fwdWrEn,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwdAddr,
    input  logic [NUM_FWD*DATA_W-1:0]     fwdData,
    output logic [DATA_W-1:0]             selData,
    output logic                          hit
);

    logic notZeroReg;

    assign notZeroReg = (regAddr != REG_ADDR_W'(ZERO_REG));

    // Walk from oldest to youngest so the lowest matching index overwrites last.
    always_comb begin
        // NOTE: every output gets a default before the loop; without it a path
        // with no match would leave the value unassigned and infer a latch.
        selData = regData;
        hit     = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (notZeroReg && fwdWrEn[i] &&
                (fwdAddr[i*REG_ADDR_W +: REG_ADDR_W] == regAddr)) begin
                selData = fwdData[i*DATA_W +: DATA_W];
                hit     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand latch with forwarding for both ALU sources and ALUSrc select.
// Optional forwarding-hit counter enabled by defining ALU_OPSTAGE_FWD_STATS_EN.
module alu_operand_stage
    import alu_opstage_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NUM_FWD    = NUM_FWD_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          stall,
    input  logic                          flush,
    input  logic [REG_ADDR_W-1:0]         rs_addr,
    input  logic [REG_ADDR_W-1:0]         rt_addr,
    input  logic [DATA_W-1:0]             rs_data,
    input  logic [DATA_W-1:0]             rt_data,
    input  logic [DATA_W-1:0]             imm,
    input  logic                          alu_src,
    input  logic [NUM_FWD-1:0]            fwd_wr_en,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD*DATA_W-1:0]     fwd_data,
    output logic [DATA_W-1:0]             op_a,
    output logic [DATA_W-1:0]             op_b,
    output logic [DATA_W-1:0]             store_data,
    output logic                          out_valid
`ifdef ALU_OPSTAGE_FWD_STATS_EN
    ,
    output logic [STATS_W-1:0]            fwd_hit_cnt
`endif
);

    logic [DATA_W-1:0] fwdA;
    logic [DATA_W-1:0] fwdRt;
    logic [DATA_W-1:0] selB;
    logic              hitA;
    logic              hitRt;
    logic              loadEn;

    fwd_select #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_FWD    (NUM_FWD)
    ) uFwdA (
        .regAddr (rs_addr),
        .regData (rs_data),
        .fwdWrEn (fwd_wr_en),
        .fwdAddr (fwd_addr),
        .fwdData (fwd_data),
        .selData (fwdA),
        .hit     (hitA)
    );

    fwd_select #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_FWD    (NUM_FWD)
    ) uFwdRt (
        .regAddr (rt_addr),
        .regData (rt_data),
        .fwdWrEn (fwd_wr_en),
        .fwdAddr (fwd_addr),
        .fwdData (fwd_data),
        .selData (fwdRt),
        .hit     (hitRt)
    );

    assign selB   = alu_src ? imm : fwdRt;
    assign loadEn = !flush && !stall;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            op_a       <= '0;
            op_b       <= '0;
            store_data <= '0;
            out_valid  <= 1'b0;
        end else if (flush) begin
            op_a       <= '0;
            op_b       <= '0;
            store_data <= '0;
            out_valid  <= 1'b0;
        end else if (!stall) begin
            op_a       <= fwdA;
            op_b       <= selB;
            store_data <= fwdRt;
            out_valid  <= in_valid;
        end
    end

`ifdef ALU_OPSTAGE_FWD_STATS_EN
    logic fwdUsed;

    // Operand B's forwarded rt only counts when the ALU actually consumes it.
    assign fwdUsed = hitA || (hitRt && !alu_src);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_hit_cnt <= '0;
        end else if (loadEn && in_valid && fwdUsed && (fwd_hit_cnt != '1)) begin
            fwd_hit_cnt <= fwd_hit_cnt + 1'b1;
        end
    end
`else
    logic unusedHits;

    assign unusedHits = hitA ^ hitRt ^ loadEn;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus randomized
// traffic against a behavioural model of the forwarding and latch rules.
module tb_alu_operand_stage;
    import alu_opstage_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NF = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          inValid, stall, flush, aluSrc;
    logic [AW-1:0] rsAddr, rtAddr;
    logic [DW-1:0] rsData, rtData, imm;
    logic [NF-1:0] fwdWe;
    logic [AW-1:0] fa [NF];
    logic [DW-1:0] fd [NF];
    logic [DW-1:0] opA, opB, storeData;
    logic          outValid;
    logic [STATS_W-1:0] fwdHitCnt;

    // Expected latch contents and statistics counter.
    logic [DW-1:0] expA, expB, expSt;
    logic          expV;
    int            expCnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_operand_stage #(.DATA_W(DW), .NUM_FWD(NF), .REG_ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (inValid),
        .stall      (stall),
        .flush      (flush),
        .rs_addr    (rsAddr),
        .rt_addr    (rtAddr),
        .rs_data    (rsData),
        .rt_data    (rtData),
        .imm        (imm),
        .alu_src    (aluSrc),
        .fwd_wr_en  (fwdWe),
        .fwd_addr   ({fa[FWD_MEMWB], fa[FWD_EXMEM]}),
        .fwd_data   ({fd[FWD_MEMWB], fd[FWD_EXMEM]}),
        .op_a       (opA),
        .op_b       (opB),
        .store_data (storeData),
        .out_valid  (outValid)
`ifdef ALU_OPSTAGE_FWD_STATS_EN
        ,
        .fwd_hit_cnt(fwdHitCnt)
`endif
    );

`ifndef ALU_OPSTAGE_FWD_STATS_EN
    assign fwdHitCnt = '0;
`endif

    // Reference: the youngest enabled source writing this nonzero register.
    function automatic int fwdSrc(input logic [AW-1:0] a);
        if (a == 0) return -1;
        for (int i = 0; i < NF; i++)
            if (fwdWe[i] && fa[i] == a) return i;
        return -1;
    endfunction

    function automatic logic [DW-1:0] fwdVal(input logic [AW-1:0] a, input logic [DW-1:0] rf);
        int s = fwdSrc(a);
        return (s < 0) ? rf : fd[s];
    endfunction

    task automatic modelEdge();
        logic [DW-1:0] rtF;
        rtF = fwdVal(rtAddr, rtData);
        if (rst) begin
            {expA, expB, expSt, expV} = '0;
            expCnt = 0;
        end else if (flush) begin
            {expA, expB, expSt, expV} = '0;
        end else if (!stall) begin
            if (inValid && (fwdSrc(rsAddr) >= 0 || (!aluSrc && fwdSrc(rtAddr) >= 0)))
                expCnt = (expCnt < 65535) ? expCnt + 1 : 65535;
            expA  = fwdVal(rsAddr, rsData);
            expB  = aluSrc ? imm : rtF;
            expSt = rtF;
            expV  = inValid;
        end
    endtask

    task automatic tick();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        inValid = 1'b0; stall = 1'b0; flush = 1'b0; aluSrc = 1'b0;
        rsAddr = '0; rtAddr = '0; rsData = '0; rtData = '0; imm = '0;
        fwdWe = '0;
        for (int i = 0; i < NF; i++) begin
            fa[i] = '0;
            fd[i] = '0;
        end
    endtask

    task automatic test_reset();
        idleInputs();
        rst = 1'b1;
        rsData = 32'h1;
        rtData = 32'h2;
        inValid = 1'b1;
        #2;
        vectors++;
        if ({opA, opB, storeData, outValid} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got a=%h b=%h s=%h v=%b, want all zero", opA, opB, storeData, outValid);
        end
        tick();
        vectors++;
        if ({opA, opB, storeData, outValid} !== '0) begin
            miscompares++;
            $display("FAIL reset_held_edge: got a=%h b=%h s=%h v=%b, want all zero", opA, opB, storeData, outValid);
        end
        rst = 1'b0;
        idleInputs();
    endtask

    task automatic test_no_fwd();
        idleInputs();
        inValid = 1'b1; rsAddr = 5'd1; rtAddr = 5'd2;
        rsData = 32'h11; rtData = 32'h22;
        tick();
        vectors++;
        if ({opA, opB, storeData, outValid} !== {32'h11, 32'h22, 32'h22, 1'b1}) begin
            miscompares++;
            $display("FAIL no_fwd: got a=%h b=%h s=%h v=%b, want 11 22 22 1", opA, opB, storeData, outValid);
        end
        // Sources writing other registers must not be picked up.
        fwdWe = 2'b11; fa[0] = 5'd3; fa[1] = 5'd4; fd[0] = 32'hC0; fd[1] = 32'hC1;
        tick();
        vectors++;
        if ({opA, opB} !== {32'h11, 32'h22}) begin
            miscompares++;
            $display("FAIL no_fwd_other_dest: got a=%h b=%h, want 11 22", opA, opB);
        end
    endtask

    task automatic test_priority();
        idleInputs();
        inValid = 1'b1; rsAddr = 5'd5; rsData = 32'h5555;
        fwdWe = 2'b11; fa[0] = 5'd5; fa[1] = 5'd5; fd[0] = 32'hAAAA; fd[1] = 32'hBBBB;
        tick();
        vectors++;
        if (opA !== 32'hAAAA) begin
            miscompares++;
            $display("FAIL dual_hit_youngest: got a=%h, want 0000aaaa", opA);
        end
        fwdWe = 2'b10;
        tick();
        vectors++;
        if (opA !== 32'hBBBB) begin
            miscompares++;
            $display("FAIL dual_hit_older: got a=%h, want 0000bbbb", opA);
        end
        fwdWe = 2'b00;
        tick();
        vectors++;
        if (opA !== 32'h5555) begin
            miscompares++;
            $display("FAIL hit_disabled: got a=%h, want 00005555", opA);
        end
    endtask

    task automatic test_imm_store();
        idleInputs();
        inValid = 1'b1; aluSrc = 1'b1; imm = 32'hFFFF_FFF8;
        rsAddr = 5'd6; rtAddr = 5'd7; rsData = 32'h66; rtData = 32'h77;
        fwdWe = 2'b01; fa[0] = 5'd7; fd[0] = 32'h1234;
        tick();
        vectors++;
        if ({opA, opB, storeData} !== {32'h66, 32'hFFFF_FFF8, 32'h1234}) begin
            miscompares++;
            $display("FAIL imm_store: got a=%h b=%h s=%h, want 66 fffffff8 1234", opA, opB, storeData);
        end
    endtask

    task automatic test_zero_guard();
        idleInputs();
        inValid = 1'b1; rsAddr = 5'd0; rtAddr = 5'd0;
        fwdWe = 2'b11; fa[0] = 5'd0; fa[1] = 5'd0; fd[0] = 32'hDEAD; fd[1] = 32'hBEEF;
        tick();
        vectors++;
        if ({opA, opB, storeData} !== '0) begin
            miscompares++;
            $display("FAIL zero_guard: got a=%h b=%h s=%h, want all zero", opA, opB, storeData);
        end
    endtask

    task automatic test_stall_flush();
        idleInputs();
        inValid = 1'b1; rsAddr = 5'd3; rsData = 32'h5; rtData = 32'h9;
        tick();
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rsData = $urandom; rtData = $urandom; inValid = 1'(c & 1);
            tick();
            vectors++;
            if ({opA, storeData, outValid} !== {32'h5, 32'h9, 1'b1}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got a=%h s=%h v=%b, want 5 9 1", c, opA, storeData, outValid);
            end
        end
        flush = 1'b1;
        tick();
        vectors++;
        if ({opA, opB, storeData, outValid} !== '0) begin
            miscompares++;
            $display("FAIL flush_beats_stall: got a=%h b=%h s=%h v=%b, want all zero", opA, opB, storeData, outValid);
        end
        // Data still loads with in_valid low.
        stall = 1'b0; flush = 1'b0; inValid = 1'b0; rsData = 32'h77;
        tick();
        vectors++;
        if ({opA, outValid} !== {32'h77, 1'b0}) begin
            miscompares++;
            $display("FAIL load_invalid: got a=%h v=%b, want 77 0", opA, outValid);
        end
    endtask

    task automatic test_async_reset();
        idleInputs();
        inValid = 1'b1; rsData = 32'hA1; rtData = 32'hB2;
        tick();
        stall = 1'b1;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({opA, opB, storeData, outValid} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got a=%h b=%h s=%h v=%b, want all zero", opA, opB, storeData, outValid);
        end
        modelEdge();
        rst = 1'b0;
        stall = 1'b0;
        tick();
        vectors++;
        if ({opA, opB, storeData, outValid} !== {32'hA1, 32'hB2, 32'hB2, 1'b1}) begin
            miscompares++;
            $display("FAIL after_reset_load: got a=%h b=%h s=%h v=%b, want a1 b2 b2 1", opA, opB, storeData, outValid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            inValid = 1'($urandom_range(0, 3) != 0);
            stall   = 1'($urandom_range(0, 7) == 0);
            flush   = 1'($urandom_range(0, 9) == 0);
            aluSrc  = 1'($urandom);
            rsAddr  = AW'($urandom_range(0, 3));
            rtAddr  = AW'($urandom_range(0, 3));
            rsData  = $urandom; rtData = $urandom; imm = $urandom;
            fwdWe   = NF'($urandom);
            for (int i = 0; i < NF; i++) begin
                fa[i] = AW'($urandom_range(0, 3));
                fd[i] = $urandom;
            end
            tick();
            vectors++;
            if ({opA, opB, storeData, outValid} !== {expA, expB, expSt, expV}) begin
                miscompares++;
                $display("FAIL random[%0d]: got a=%h b=%h s=%h v=%b, want a=%h b=%h s=%h v=%b",
                         n, opA, opB, storeData, outValid, expA, expB, expSt, expV);
            end
`ifdef ALU_OPSTAGE_FWD_STATS_EN
            vectors++;
            if (fwdHitCnt !== 16'(expCnt)) begin
                miscompares++;
                $display("FAIL random_cnt[%0d]: got %0d, want %0d", n, fwdHitCnt, expCnt);
            end
`endif
        end
        idleInputs();
    endtask

`ifdef ALU_OPSTAGE_FWD_STATS_EN
    task automatic test_stats();
        idleInputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        // rt hit with alu_src=1 does not count; stall and flush do not count.
        inValid = 1'b1; aluSrc = 1'b1; rtAddr = 5'd2;
        fwdWe = 2'b01; fa[0] = 5'd2;
        tick();
        stall = 1'b1; rsAddr = 5'd2;
        tick();
        flush = 1'b1;
        tick();
        vectors++;
        if (fwdHitCnt !== 16'd0) begin
            miscompares++;
            $display("FAIL stats_no_count: got %0d, want 0", fwdHitCnt);
        end
        stall = 1'b0; flush = 1'b0;
        for (int c = 0; c < 70000; c++) tick();
        vectors++;
        if (fwdHitCnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL stats_saturate: got %h, want ffff", fwdHitCnt);
        end
        idleInputs();
    endtask
`endif

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        expCnt = 0;
        {expA, expB, expSt, expV} = '0;
        test_reset();
        test_no_fwd();
        test_priority();
        test_imm_store();
        test_zero_guard();
        test_stall_flush();
        test_async_reset();
        test_random();
`ifdef ALU_OPSTAGE_FWD_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
